// File: rtl/mem_responder.sv
// Fixed-latency line memory that answers cache fill (read) and write-back requests.
// Latency: accept at edge E0 -> resp_valid for the single cycle after edge E0+LATENCY.
// Backpressure: req_ready is low from acceptance until the resp_valid cycle; one request in flight.
//
// Ports:
//   clk, reset            single clock; asynchronous active-high reset
//   req_valid/req_ready   request handshake; accepted on a rising edge with both high
//   req_write             1 = line write-back, 0 = line fill
//   req_addr              byte address; line index = req_addr[4 +: log2(LINES)]
//   req_wdata             write-back line data
//   resp_valid            one-cycle completion strobe
//   resp_rdata            fill data, meaningful while resp_valid=1 for a read
//   busy                  high while a transaction is in WAIT or RESP
module mem_responder #(
  parameter int LATENCY = 5,
  parameter int LINES   = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  input  logic         req_write,
  input  logic [31:0]  req_addr,
  input  logic [127:0] req_wdata,
  output logic         req_ready,
  output logic         resp_valid,
  output logic [127:0] resp_rdata,
  output logic         busy
);

  localparam int IDX_W = (LINES > 1) ? $clog2(LINES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic               wr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [127:0]       wdata_q;

  // Line storage: zero at time zero, deliberately outside the reset domain.
  logic [127:0]       mem [LINES] = '{default: '0};

  logic               accept;
  logic               enter_resp;
  logic               cur_write;
  logic [IDX_W-1:0]   cur_idx;
  logic [IDX_W-1:0]   req_idx;
  logic [127:0]       cur_wdata;

  // Offset bits and bits above the index take no part in addressing.
  logic               unused_addr;
  assign unused_addr = ^(req_addr & ~(32'(LINES - 1) << 4));

  assign req_idx   = req_addr[4 +: IDX_W];
  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;
  assign accept    = (state == IDLE) && req_valid;

  // With LATENCY=1 the RESP entry coincides with acceptance, so the
  // transaction fields come straight from the request inputs that edge.
  assign enter_resp = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == 4'd1));
  assign cur_write  = (state == IDLE) ? req_write : wr_q;
  assign cur_idx    = (state == IDLE) ? req_idx   : idx_q;
  assign cur_wdata  = (state == IDLE) ? req_wdata : wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
    end else begin
      // The strobe follows the RESP cycle, so it coincides with the return to IDLE.
      resp_valid <= (state == RESP);

      if (enter_resp && !cur_write) begin
        resp_rdata <= mem[cur_idx];
      end

      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            idx_q   <= req_idx;
            wdata_q <= req_wdata;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              cnt   <= 4'(LATENCY - 1);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Commit happens on the RESP entry edge; a reset before then drops the write.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && cur_write) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder (LATENCY=5) plus a directed LATENCY=1 instance.
// Timing: responses expected for the cycle after edge E0+LATENCY, checked on the falling edge.
// Backpressure: driver waits on req_ready; optional continuous req_valid hold.
module tb_mem_responder;

  localparam int LAT = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_write;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic         req_ready, resp_valid, busy;
  logic [127:0] resp_rdata;

  logic         v1, w1;
  logic [31:0]  a1;
  logic [127:0] d1;
  logic         ready1, rv1, busy1;
  logic [127:0] rd1;

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(LAT), .LINES(256)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy)
  );

  mem_responder #(.LATENCY(1), .LINES(256)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(v1), .req_write(w1), .req_addr(a1), .req_wdata(d1),
    .req_ready(ready1), .resp_valid(rv1), .resp_rdata(rd1), .busy(busy1)
  );

  typedef struct {
    int           due;
    bit           wr;
    logic [127:0] data;
  } exp_t;

  exp_t         sbq[$];
  logic [127:0] model [256];
  int           checks = 0;
  int           fails = 0;
  int           cyc = 0;
  int           busy_until = -1;
  int           last_acc = 0;
  bit           mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32'd16) % 32'd256);
  endfunction

  // Monitor: idle/busy expectation from the model, responses popped from the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && mon_en) begin
      check("req_ready", 128'(req_ready), 128'(cyc > busy_until));
      check("busy", 128'(busy), 128'(cyc <= busy_until));
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected resp_valid", 128'(resp_valid), 128'(0));
        end else begin
          e = sbq.pop_front();
          check("resp timing", 128'(cyc), 128'(e.due));
          if (!e.wr) check("resp_rdata", resp_rdata, e.data);
        end
      end else if (sbq.size() > 0 && cyc >= sbq[0].due) begin
        check("missing resp_valid", 128'(resp_valid), 128'(1));
        void'(sbq.pop_front());
      end
    end
  end

  // Present a request, wait for acceptance, then record the expected outcome.
  task automatic issue(input bit w, input logic [31:0] a, input logic [127:0] d,
                       input bit hold, input bit track);
    int n = 0;
    int e0;
    @(negedge clk);
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("req_ready timeout", 128'(req_ready), 128'(1));
      req_valid = 1'b0;
      return;
    end
    e0 = cyc + 1;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    if (track) begin
      exp_t e;
      e.due  = e0 + LAT;
      e.wr   = w;
      e.data = w ? 128'(0) : model[line_of(a)];
      sbq.push_back(e);
      if (w) model[line_of(a)] = d;
    end
    busy_until = e0 + LAT - 1;
    last_acc   = e0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() > 0) check("drain timeout", 128'(sbq.size()), 128'(0));
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [127:0] da, db, d3, rnd;
    logic [31:0]  a;
    int           prev, gap;
    bit           w, hold, saw;

    for (int i = 0; i < 256; i++) model[i] = '0;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    v1 = 0; w1 = 0; a1 = 0; d1 = 0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("reset req_ready", 128'(req_ready), 128'(1));
    check("reset busy", 128'(busy), 128'(0));
    check("reset resp_valid", 128'(resp_valid), 128'(0));
    check("reset resp_rdata", resp_rdata, 128'(0));
    check("reset req_ready L1", 128'(ready1), 128'(1));
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    mon_en = 1'b1;

    // Read of a never-written line, then same-line write/read with offset, then wrap-around.
    issue(0, 32'h40, '0, 0, 1);
    drain();
    da = 128'h0123456789ABCDEF0123456789ABCDEF;
    issue(1, 32'h40, da, 0, 1);
    issue(0, 32'h4C, '0, 0, 1);
    issue(1, 32'h1040, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 0, 1);
    issue(0, 32'h0040, '0, 0, 1);
    drain();

    // Continuous req_valid: acceptances spaced LATENCY+1 apart.
    for (int k = 0; k < 5; k++) begin
      prev = last_acc;
      issue(0, 32'h40 + 32'(k), '0, (k < 4), 1);
      if (k > 0) check("accept spacing", 128'(last_acc - prev), 128'(LAT + 1));
    end
    drain();

    // Randomized traffic over a few lines, with aliasing upper/offset address bits.
    for (int k = 0; k < 60; k++) begin
      w    = 1'($urandom_range(0, 1));
      a    = ($urandom & 32'hFFFF_F00F) | (32'($urandom_range(0, 7)) << 4);
      rnd  = {$urandom, $urandom, $urandom, $urandom};
      gap  = $urandom_range(0, 2);
      hold = (gap == 0) && (k < 59) && ($urandom_range(0, 1) == 1);
      issue(w, a, rnd, hold, 1);
      repeat (gap) @(negedge clk);
    end
    drain();

    // Reset in the second WAIT cycle aborts a write and its response.
    db = 128'hFEED_FACE_CAFE_BEEF_0000_1234_5678_9ABC;
    issue(1, 32'h30, db, 0, 1);
    issue(0, 32'h30, '0, 0, 1);
    drain();
    issue(1, 32'h30, ~db, 0, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort req_ready", 128'(req_ready), 128'(1));
    check("abort busy", 128'(busy), 128'(0));
    check("abort resp_valid", 128'(resp_valid), 128'(0));
    check("abort resp_rdata", resp_rdata, 128'(0));
    busy_until = -1;
    @(posedge clk);
    #2 reset = 1'b0;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw = saw | resp_valid;
    end
    check("aborted resp_valid", 128'(saw), 128'(0));
    issue(0, 32'h30, '0, 0, 1);
    drain();

    // LATENCY=1 instance: response one cycle after acceptance, next acceptance two cycles later.
    d3 = 128'h1357_9BDF_2468_ACE0_1122_3344_5566_7788;
    @(negedge clk);
    check("L1 req_ready idle", 128'(ready1), 128'(1));
    w1 = 1'b1; a1 = 32'h20; d1 = d3; v1 = 1'b1;
    @(posedge clk);
    #1 v1 = 1'b0;
    @(negedge clk);
    check("L1 req_ready after accept", 128'(ready1), 128'(0));
    check("L1 resp_valid after accept", 128'(rv1), 128'(0));
    @(negedge clk);
    check("L1 resp_valid strobe", 128'(rv1), 128'(1));
    check("L1 req_ready in strobe", 128'(ready1), 128'(1));
    w1 = 1'b0; a1 = 32'h2C; v1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("L1 held resp_valid", 128'(rv1), 128'(k % 2));
      check("L1 held req_ready", 128'(ready1), 128'(k % 2));
      if (k % 2 == 1) check("L1 rdata", rd1, d3);
    end
    v1 = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
